// File: rtl/respondedor_memoria_dados.sv
// Data-memory responder for the load/store port: byte-addressed little-endian RAM behind a
// valid/ready handshake with wait states. Optional access counters via CONTADORES_ACESSO_EN.
module respondedor_memoria_dados #(
  parameter int unsigned LARGURA_END   = 10,
  parameter int unsigned CICLOS_ESPERA = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valido,
  output logic        req_pronto,
  input  logic        req_escrita,
  input  logic [1:0]  req_tamanho,
  input  logic        req_com_sinal,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dados_escrita,
  output logic        resp_valido,
  input  logic        resp_pronto,
  output logic [31:0] resp_dados_leitura,
  output logic        resp_erro
`ifdef CONTADORES_ACESSO_EN
  ,
  output logic [31:0] cont_leituras,
  output logic [31:0] cont_escritas,
  output logic [31:0] cont_erros
`endif
);

  localparam int unsigned NumBytes = 2 ** LARGURA_END;

  typedef enum logic [1:0] {StOcioso, StEspera, StResposta} estado_e;

  estado_e                  estado_q, estado_d;
  logic [3:0]               espera_q, espera_d;
  logic                     escrita_q, escrita_d;
  logic [1:0]               tamanho_q, tamanho_d;
  logic                     com_sinal_q, com_sinal_d;
  logic [LARGURA_END-1:0]   endereco_q, endereco_d;
  logic [31:0]              dados_q, dados_d;
  logic                     erro_q, erro_d;
  logic [31:0]              leitura_q, leitura_d;
  logic                     req_pronto_q, req_pronto_d;
  logic                     resp_valido_q, resp_valido_d;
  logic                     resp_erro_q, resp_erro_d;
  logic [31:0]              resp_dados_q, resp_dados_d;

  logic [7:0] mem [NumBytes];

  logic                   aceita;
  logic                   erro_req;
  logic                   origem_ocioso;
  logic                   entra_resposta;
  logic                   mem_we;
  logic                   a_escrita;
  logic [1:0]             a_tamanho;
  logic                   a_com_sinal;
  logic [LARGURA_END-1:0] a_end;
  logic [31:0]            a_dados;
  logic                   a_erro;
  logic [LARGURA_END-1:0] idx1, idx2, idx3;
  logic [31:0]            bruto;
  logic [31:0]            carga;

  assign aceita        = req_valido && req_pronto_q;
  assign origem_ocioso = (estado_q == StOcioso);

  assign erro_req = (req_tamanho == 2'b11)
                 || ((req_tamanho == 2'b01) && req_endereco[0])
                 || ((req_tamanho == 2'b10) && (req_endereco[1:0] != 2'b00))
                 || (|req_endereco[31:LARGURA_END]);

  // With zero wait states the access happens on the accept edge, so the live request is used.
  always_comb begin
    a_escrita   = origem_ocioso ? req_escrita : escrita_q;
    a_tamanho   = origem_ocioso ? req_tamanho : tamanho_q;
    a_com_sinal = origem_ocioso ? req_com_sinal : com_sinal_q;
    a_end       = origem_ocioso ? req_endereco[LARGURA_END-1:0] : endereco_q;
    a_dados     = origem_ocioso ? req_dados_escrita : dados_q;
    a_erro      = origem_ocioso ? erro_req : erro_q;
    idx1        = a_end + LARGURA_END'(1);
    idx2        = a_end + LARGURA_END'(2);
    idx3        = a_end + LARGURA_END'(3);
  end

  assign entra_resposta = (origem_ocioso && aceita && (CICLOS_ESPERA == 0))
                       || ((estado_q == StEspera) && (espera_q == 4'd0));
  assign mem_we = entra_resposta && a_escrita && !a_erro && !reset;

  always_comb begin
    bruto = {mem[idx3], mem[idx2], mem[idx1], mem[a_end]};
    case (a_tamanho)
      2'b00:   carga = {{24{a_com_sinal & bruto[7]}}, bruto[7:0]};
      2'b01:   carga = {{16{a_com_sinal & bruto[15]}}, bruto[15:0]};
      default: carga = bruto;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[a_end] <= a_dados[7:0];
      if (a_tamanho != 2'b00) begin
        mem[idx1] <= a_dados[15:8];
      end
      if (a_tamanho == 2'b10) begin
        mem[idx2] <= a_dados[23:16];
        mem[idx3] <= a_dados[31:24];
      end
    end
  end

  always_comb begin
    estado_d      = estado_q;
    espera_d      = espera_q;
    escrita_d     = escrita_q;
    tamanho_d     = tamanho_q;
    com_sinal_d   = com_sinal_q;
    endereco_d    = endereco_q;
    dados_d       = dados_q;
    erro_d        = erro_q;
    leitura_d     = leitura_q;
    req_pronto_d  = req_pronto_q;
    resp_valido_d = resp_valido_q;
    resp_erro_d   = resp_erro_q;
    resp_dados_d  = resp_dados_q;

    if (entra_resposta) begin
      leitura_d = (a_escrita || a_erro) ? 32'd0 : carga;
    end

    unique case (estado_q)
      StOcioso: begin
        if (aceita) begin
          escrita_d    = req_escrita;
          tamanho_d    = req_tamanho;
          com_sinal_d  = req_com_sinal;
          endereco_d   = req_endereco[LARGURA_END-1:0];
          dados_d      = req_dados_escrita;
          erro_d       = erro_req;
          req_pronto_d = 1'b0;
          if (CICLOS_ESPERA == 0) begin
            estado_d = StResposta;
          end else begin
            estado_d = StEspera;
            espera_d = 4'(CICLOS_ESPERA - 1);
          end
        end
      end
      StEspera: begin
        if (espera_q == 4'd0) begin
          estado_d = StResposta;
        end else begin
          espera_d = espera_q - 4'd1;
        end
      end
      StResposta: begin
        // First cycle publishes the registered access result; then wait for the consumer.
        if (!resp_valido_q) begin
          resp_valido_d = 1'b1;
          resp_erro_d   = erro_q;
          resp_dados_d  = leitura_q;
        end else if (resp_pronto) begin
          estado_d      = StOcioso;
          resp_valido_d = 1'b0;
          resp_erro_d   = 1'b0;
          resp_dados_d  = 32'd0;
          req_pronto_d  = 1'b1;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q      <= StOcioso;
      espera_q      <= 4'd0;
      escrita_q     <= 1'b0;
      tamanho_q     <= 2'b00;
      com_sinal_q   <= 1'b0;
      endereco_q    <= '0;
      dados_q       <= 32'd0;
      erro_q        <= 1'b0;
      leitura_q     <= 32'd0;
      req_pronto_q  <= 1'b1;
      resp_valido_q <= 1'b0;
      resp_erro_q   <= 1'b0;
      resp_dados_q  <= 32'd0;
    end else begin
      estado_q      <= estado_d;
      espera_q      <= espera_d;
      escrita_q     <= escrita_d;
      tamanho_q     <= tamanho_d;
      com_sinal_q   <= com_sinal_d;
      endereco_q    <= endereco_d;
      dados_q       <= dados_d;
      erro_q        <= erro_d;
      leitura_q     <= leitura_d;
      req_pronto_q  <= req_pronto_d;
      resp_valido_q <= resp_valido_d;
      resp_erro_q   <= resp_erro_d;
      resp_dados_q  <= resp_dados_d;
    end
  end

  assign req_pronto         = req_pronto_q;
  assign resp_valido        = resp_valido_q;
  assign resp_erro          = resp_erro_q;
  assign resp_dados_leitura = resp_dados_q;

`ifdef CONTADORES_ACESSO_EN
  logic        consome;
  logic [31:0] cont_leituras_q, cont_leituras_d;
  logic [31:0] cont_escritas_q, cont_escritas_d;
  logic [31:0] cont_erros_q, cont_erros_d;

  assign consome = (estado_q == StResposta) && resp_valido_q && resp_pronto;

  always_comb begin
    cont_leituras_d = cont_leituras_q;
    cont_escritas_d = cont_escritas_q;
    cont_erros_d    = cont_erros_q;
    if (consome) begin
      if (erro_q) begin
        if (cont_erros_q != '1) cont_erros_d = cont_erros_q + 32'd1;
      end else if (escrita_q) begin
        if (cont_escritas_q != '1) cont_escritas_d = cont_escritas_q + 32'd1;
      end else begin
        if (cont_leituras_q != '1) cont_leituras_d = cont_leituras_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_leituras_q <= 32'd0;
      cont_escritas_q <= 32'd0;
      cont_erros_q    <= 32'd0;
    end else begin
      cont_leituras_q <= cont_leituras_d;
      cont_escritas_q <= cont_escritas_d;
      cont_erros_q    <= cont_erros_d;
    end
  end

  assign cont_leituras = cont_leituras_q;
  assign cont_escritas = cont_escritas_q;
  assign cont_erros    = cont_erros_q;
`endif

endmodule

// File: tb/tb_respondedor_memoria_dados.sv
// Bench for respondedor_memoria_dados: three instances (1, 3 and 0 wait states) checked against
// a byte-array reference model with directed and randomized load/store traffic.
`timescale 1ns/1ps
module tb_respondedor_memoria_dados;
  localparam int ND = 3;
  localparam int unsigned LE = 10;

  logic        clk;
  logic        reset;
  logic        req_valido         [ND];
  logic        req_pronto         [ND];
  logic        req_escrita        [ND];
  logic [1:0]  req_tamanho        [ND];
  logic        req_com_sinal      [ND];
  logic [31:0] req_endereco       [ND];
  logic [31:0] req_dados_escrita  [ND];
  logic        resp_valido        [ND];
  logic        resp_pronto        [ND];
  logic [31:0] resp_dados_leitura [ND];
  logic        resp_erro          [ND];
`ifdef CONTADORES_ACESSO_EN
  logic [31:0] cont_leituras [ND];
  logic [31:0] cont_escritas [ND];
  logic [31:0] cont_erros    [ND];
`endif

  int total = 0;
  int bad   = 0;

  byte unsigned mdl [ND][1024];
  int unsigned  m_lei [ND];
  int unsigned  m_esc [ND];
  int unsigned  m_err [ND];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned Cic = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    respondedor_memoria_dados #(
      .LARGURA_END  (LE),
      .CICLOS_ESPERA(Cic)
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .req_valido        (req_valido[g]),
      .req_pronto        (req_pronto[g]),
      .req_escrita       (req_escrita[g]),
      .req_tamanho       (req_tamanho[g]),
      .req_com_sinal     (req_com_sinal[g]),
      .req_endereco      (req_endereco[g]),
      .req_dados_escrita (req_dados_escrita[g]),
      .resp_valido       (resp_valido[g]),
      .resp_pronto       (resp_pronto[g]),
      .resp_dados_leitura(resp_dados_leitura[g]),
      .resp_erro         (resp_erro[g])
`ifdef CONTADORES_ACESSO_EN
      ,
      .cont_leituras     (cont_leituras[g]),
      .cont_escritas     (cont_escritas[g]),
      .cont_erros        (cont_erros[g])
`endif
    );
  end

  function automatic int cic(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  // Reference: byte array, rules applied arithmetically per access.
  task automatic modelo(input int d, input bit wr, input logic [1:0] tam, input bit sig,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output bit err);
    int     n;
    longint v;
    n   = (tam == 2'd0) ? 1 : ((tam == 2'd1) ? 2 : 4);
    err = (addr >= 32'd1024) || (tam == 2'd3) || ((addr % n) != 0);
    rd  = 32'd0;
    if (err) begin
      m_err[d]++;
    end else if (wr) begin
      m_esc[d]++;
      for (int k = 0; k < n; k++) mdl[d][int'(addr) + k] = byte'((wd >> (8 * k)) & 32'hFF);
    end else begin
      m_lei[d]++;
      v = 0;
      for (int k = 0; k < n; k++) v = v + (longint'(mdl[d][int'(addr) + k]) << (8 * k));
      if (sig && (n < 4) && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
      rd = v[31:0];
    end
  endtask

  task automatic aplica_reset(input int ciclos);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      req_valido[d] = 1'b0;  req_escrita[d] = 1'b0;  req_tamanho[d] = 2'd0;
      req_com_sinal[d] = 1'b0; req_endereco[d] = 32'd0; req_dados_escrita[d] = 32'd0;
      resp_pronto[d] = 1'b0;
      m_lei[d] = 0; m_esc[d] = 0; m_err[d] = 0;
    end
    repeat (ciclos) @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver only: issues one request, returns response fields and accept-to-valid latency.
  task automatic transacao(input int d, input bit wr, input logic [1:0] tam, input bit sig,
                           input logic [31:0] addr, input logic [31:0] wd, input int atraso,
                           output logic [31:0] rd, output bit err, output int lat);
    int guarda;
    guarda = 0;
    while (req_pronto[d] !== 1'b1 && guarda < 50) begin @(negedge clk); guarda++; end
    req_escrita[d] = wr; req_tamanho[d] = tam; req_com_sinal[d] = sig;
    req_endereco[d] = addr; req_dados_escrita[d] = wd; req_valido[d] = 1'b1;
    @(negedge clk);
    req_valido[d] = 1'b0;
    req_escrita[d] = 1'($urandom); req_tamanho[d] = 2'($urandom);
    req_com_sinal[d] = 1'($urandom); req_endereco[d] = $urandom; req_dados_escrita[d] = $urandom;
    lat = 0;
    while (resp_valido[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    repeat (atraso) @(negedge clk);
    rd  = resp_dados_leitura[d];
    err = resp_erro[d];
    resp_pronto[d] = 1'b1;
    @(negedge clk);
    resp_pronto[d] = 1'b0;
  endtask

  task automatic test_reset();
    aplica_reset(2);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (req_pronto[d] !== 1'b1) begin
        bad++; $display("FAIL reset_req_pronto d=%0d got=%b want=1", d, req_pronto[d]);
      end
      total++;
      if (resp_valido[d] !== 1'b0) begin
        bad++; $display("FAIL reset_resp_valido d=%0d got=%b want=0", d, resp_valido[d]);
      end
      total++;
      if (resp_erro[d] !== 1'b0) begin
        bad++; $display("FAIL reset_resp_erro d=%0d got=%b want=0", d, resp_erro[d]);
      end
      total++;
      if (resp_dados_leitura[d] !== 32'd0) begin
        bad++; $display("FAIL reset_dados d=%0d got=%h want=0", d, resp_dados_leitura[d]);
      end
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, er, w;
    bit e, ee;
    int lat;
    for (int d = 0; d < ND; d++) begin
      for (int a = 0; a < 256; a += 4) begin
        w = $urandom;
        modelo(d, 1'b1, 2'd2, 1'b0, 32'(a), w, er, ee);
        transacao(d, 1'b1, 2'd2, 1'b0, 32'(a), w, 0, rd, e, lat);
        total++;
        if (e !== ee || rd !== er || lat != cic(d) + 1) begin
          bad++;
          $display("FAIL init_sw d=%0d a=%h got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d",
                   d, a, e, rd, lat, ee, er, cic(d) + 1);
        end
      end
    end
  endtask

  task automatic test_sh_lh();
    logic [31:0] rd, er;
    bit e, ee;
    int lat;
    for (int d = 0; d < ND; d += 2) begin
      modelo(d, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000F00D, er, ee);
      transacao(d, 1'b1, 2'd1, 1'b0, 32'h10, 32'h0000F00D, 0, rd, e, lat);
      total++;
      if (e !== 1'b0 || rd !== 32'd0 || lat != cic(d) + 1) begin
        bad++; $display("FAIL sh d=%0d got err=%b rd=%h lat=%0d want err=0 rd=0 lat=%0d",
                        d, e, rd, lat, cic(d) + 1);
      end
      modelo(d, 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, er, ee);
      transacao(d, 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 0, rd, e, lat);
      total++;
      if (rd !== 32'hFFFFF00D || e !== 1'b0 || lat != cic(d) + 1) begin
        bad++; $display("FAIL lh d=%0d got rd=%h err=%b lat=%0d want rd=fffff00d err=0 lat=%0d",
                        d, rd, e, lat, cic(d) + 1);
      end
      modelo(d, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, er, ee);
      transacao(d, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 1, rd, e, lat);
      total++;
      if (rd !== 32'h000000F0) begin
        bad++; $display("FAIL lbu_11 d=%0d got=%h want=000000f0", d, rd);
      end
      modelo(d, 1'b0, 2'd0, 1'b1, 32'h10, 32'd0, er, ee);
      transacao(d, 1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 0, rd, e, lat);
      total++;
      if (rd !== 32'h0000000D) begin
        bad++; $display("FAIL lb_10 d=%0d got=%h want=0000000d", d, rd);
      end
    end
  endtask

  task automatic test_parcial();
    logic [31:0] rd, er;
    bit e, ee;
    int lat;
    modelo(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, er, ee);
    transacao(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, rd, e, lat);
    modelo(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000AABB, er, ee);
    transacao(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000AABB, 0, rd, e, lat);
    modelo(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, er, ee);
    transacao(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, rd, e, lat);
    total++;
    if (rd !== 32'hAABB3344 || e !== 1'b0) begin
      bad++; $display("FAIL parcial_lw got rd=%h err=%b want rd=aabb3344 err=0", rd, e);
    end
  endtask

  task automatic test_erros();
    logic [31:0] rd, er;
    bit e, ee;
    int lat;
    modelo(0, 1'b0, 2'd1, 1'b1, 32'h13, 32'd0, er, ee);
    transacao(0, 1'b0, 2'd1, 1'b1, 32'h13, 32'd0, 0, rd, e, lat);
    total++;
    if (e !== 1'b1 || rd !== 32'd0 || lat != 2) begin
      bad++; $display("FAIL err_lh13 got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", e, rd, lat);
    end
    modelo(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, er, ee);
    transacao(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 0, rd, e, lat);
    total++;
    if (e !== 1'b1 || rd !== 32'd0 || lat != 2) begin
      bad++; $display("FAIL err_sw400 got err=%b rd=%h lat=%0d want err=1 rd=0 lat=2", e, rd, lat);
    end
    modelo(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, er, ee);
    transacao(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 0, rd, e, lat);
    total++;
    if (rd !== er || e !== 1'b0) begin
      bad++; $display("FAIL err_mem_intacta got rd=%h err=%b want rd=%h err=0", rd, e, er);
    end
    modelo(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h01020304, er, ee);
    transacao(0, 1'b1, 2'd2, 1'b0, 32'h22, 32'h01020304, 0, rd, e, lat);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL err_sw22 got err=%b want err=1", e);
    end
    modelo(2, 1'b0, 2'd3, 1'b0, 32'h4, 32'd0, er, ee);
    transacao(2, 1'b0, 2'd3, 1'b0, 32'h4, 32'd0, 0, rd, e, lat);
    total++;
    if (e !== 1'b1 || rd !== 32'd0 || lat != 1) begin
      bad++; $display("FAIL err_tam11 got err=%b rd=%h lat=%0d want err=1 rd=0 lat=1", e, rd, lat);
    end
    modelo(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, er, ee);
    transacao(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0, rd, e, lat);
    total++;
    if (rd !== er || e !== 1'b0) begin
      bad++; $display("FAIL err_sw22_sem_efeito got rd=%h want rd=%h", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] er, cap, rd;
    bit ee, e, ok;
    int guarda, lat;
    modelo(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, er, ee);
    req_escrita[0] = 1'b0; req_tamanho[0] = 2'd2; req_com_sinal[0] = 1'b0;
    req_endereco[0] = 32'h20; req_valido[0] = 1'b1;
    @(negedge clk);
    // A competing store stays offered the whole time; it must never be taken while busy.
    req_escrita[0] = 1'b1; req_endereco[0] = 32'h24; req_dados_escrita[0] = 32'h5A5A5A5A;
    guarda = 0;
    while (resp_valido[0] !== 1'b1 && guarda < 50) begin
      total++;
      if (req_pronto[0] !== 1'b0) begin
        bad++; $display("FAIL bp_pronto_espera got=%b want=0", req_pronto[0]);
      end
      @(negedge clk); guarda++;
    end
    cap = resp_dados_leitura[0];
    total++;
    if (cap !== er || resp_valido[0] !== 1'b1) begin
      bad++; $display("FAIL bp_dados got=%h valido=%b want=%h valido=1", cap, resp_valido[0], er);
    end
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valido[0] !== 1'b1 || resp_dados_leitura[0] !== cap || req_pronto[0] !== 1'b0)
        ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_estavel got valido=%b dados=%h pronto=%b want 1/%h/0",
                      resp_valido[0], resp_dados_leitura[0], req_pronto[0], cap);
    end
    resp_pronto[0] = 1'b1;
    @(negedge clk);
    resp_pronto[0] = 1'b0;
    total++;
    if (req_pronto[0] !== 1'b1 || resp_valido[0] !== 1'b0) begin
      bad++; $display("FAIL bp_pos_consumo got pronto=%b valido=%b want pronto=1 valido=0",
                      req_pronto[0], resp_valido[0]);
    end
    req_valido[0] = 1'b0;
    modelo(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0, er, ee);
    transacao(0, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0, 0, rd, e, lat);
    total++;
    if (rd !== er) begin
      bad++; $display("FAIL bp_store_recusado got=%h want=%h", rd, er);
    end
  endtask

  task automatic test_reset_espera();
    logic [31:0] rd, er;
    bit e, ee, ok;
    int lat;
    modelo(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE5678, er, ee);
    transacao(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE5678, 0, rd, e, lat);
    total++;
    if (lat != 4 || e !== 1'b0) begin
      bad++; $display("FAIL re_lat_c3 got lat=%0d err=%b want lat=4 err=0", lat, e);
    end
    req_escrita[1] = 1'b1; req_tamanho[1] = 2'd1; req_endereco[1] = 32'h30;
    req_dados_escrita[1] = 32'h00001234; req_valido[1] = 1'b1;
    @(negedge clk);
    req_valido[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin m_lei[d] = 0; m_esc[d] = 0; m_err[d] = 0; end
    ok = 1'b1;
    repeat (6) begin
      if (resp_valido[1] !== 1'b0 || req_pronto[1] !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL re_ocioso got valido=%b pronto=%b want valido=0 pronto=1",
                      resp_valido[1], req_pronto[1]);
    end
`ifdef CONTADORES_ACESSO_EN
    total++;
    if (cont_leituras[1] !== 32'd0 || cont_escritas[1] !== 32'd0 || cont_erros[1] !== 32'd0) begin
      bad++; $display("FAIL re_contadores got l=%0d w=%0d e=%0d want 0/0/0",
                      cont_leituras[1], cont_escritas[1], cont_erros[1]);
    end
`endif
    modelo(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, er, ee);
    transacao(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 0, rd, e, lat);
    total++;
    if (rd !== 32'hCAFE5678 || rd !== er) begin
      bad++; $display("FAIL re_store_descartado got=%h want=cafe5678", rd);
    end
  endtask

  task automatic test_aleatorio();
    logic [31:0] rd, er, addr, wd;
    logic [1:0] tam;
    bit e, ee, wr, sig;
    int lat, sel;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 40; i++) begin
        wr  = 1'($urandom);
        sig = 1'($urandom);
        tam = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        wd  = $urandom;
        sel = $urandom_range(0, 9);
        if (sel == 0) addr = $urandom | 32'h400;
        else if (sel == 1) addr = 32'($urandom_range(0, 255));
        else addr = 32'($urandom_range(0, 63)) * 4 + ((tam == 2'd0) ? 32'($urandom_range(0, 3)) :
                    (tam == 2'd1) ? 32'($urandom_range(0, 1)) * 2 : 32'd0);
        modelo(d, wr, tam, sig, addr, wd, er, ee);
        transacao(d, wr, tam, sig, addr, wd, $urandom_range(0, 3), rd, e, lat);
        total++;
        if (rd !== er || e !== ee || lat != cic(d) + 1) begin
          bad++;
          $display("FAIL rand d=%0d i=%0d wr=%b tam=%0d a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                   d, i, wr, tam, addr, rd, e, lat, er, ee, cic(d) + 1);
        end
      end
    end
  endtask

`ifdef CONTADORES_ACESSO_EN
  task automatic test_contadores();
    for (int d = 0; d < ND; d++) begin
      total++;
      if (cont_leituras[d] !== 32'(m_lei[d]) || cont_escritas[d] !== 32'(m_esc[d]) ||
          cont_erros[d] !== 32'(m_err[d])) begin
        bad++; $display("FAIL contadores d=%0d got l=%0d w=%0d e=%0d want l=%0d w=%0d e=%0d",
                        d, cont_leituras[d], cont_escritas[d], cont_erros[d],
                        m_lei[d], m_esc[d], m_err[d]);
      end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_sh_lh();
    test_parcial();
    test_erros();
    test_backpressure();
    test_reset_espera();
    test_aleatorio();
`ifdef CONTADORES_ACESSO_EN
    test_contadores();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
